bsg_link_upstream_credit_arbiter: RTL and testbench

Shares one bsg_link DDR upstream channel among NUM_REQ core-side requesters. Arbitration is round-robin. Each send is gated by a credit counter, which is replenished by token pulses returned from the downstream side. The block sits between the core requesters and bsg_link_ddr_upstream's core_valid_i/core_data_i/core_ready_o interface, in the core clock domain.

---
 rtl/bsg_link_upstream_credit_arbiter.sv | 129 ++++++++++++
 tb/tb_bsg_link_upstream_credit_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_link_upstream_credit_arbiter.sv
// Round-robin arbiter sharing one bsg_link upstream channel among NUM_REQ requesters,
// with each send gated by a token-replenished credit counter.
module bsg_link_upstream_credit_arbiter #(
    parameter int NUM_REQ            = 4,
    parameter int WIDTH              = 64,
    parameter int MAX_CREDITS        = 64,
    parameter int LG_CREDIT_TO_TOKEN = 3,
    parameter int CREDIT_W           = $clog2(MAX_CREDITS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       link_valid_o,
    output logic [WIDTH-1:0]           link_data_o,
    output logic [$clog2(NUM_REQ)-1:0] link_id_o,
    input  logic                       link_ready_i,
    input  logic                       token_i,
    output logic [CREDIT_W-1:0]        credit_o,
    output logic [6:0]                 sent_cnt_o,
    output logic                       stall_o,
    output logic                       overflow_err_o
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [CREDIT_W:0] TOKEN_INC = (CREDIT_W+1)'(1 << LG_CREDIT_TO_TOKEN);
    localparam logic [CREDIT_W:0] MAX_EXT   = (CREDIT_W+1)'(MAX_CREDITS);

    typedef enum logic {IDLE, OFFER} state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [6:0]           sent_q, sent_d;
    logic                 ovf_q, ovf_d;

    logic [ID_W-1:0]      win;
    logic                 win_found;
    logic                 handshake;
    logic                 can_grant;
    logic [CREDIT_W:0]    credit_sum;

    // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = (32'(rr_q) + k) % NUM_REQ;
            if (!win_found && req_valid_i[idx]) begin
                win_found = 1'b1;
                win       = ID_W'(idx);
            end
        end
    end

    always_comb begin
        handshake = (state_q == OFFER) && link_ready_i;
        // rst gating keeps every ready low while reset is held, even with credits present.
        can_grant = !rst && (credit_q != '0) && win_found
                    && ((state_q == IDLE) || handshake);
        req_ready_o = can_grant ? (NUM_REQ'(1) << win) : '0;
        stall_o     = (credit_q == '0) && (|req_valid_i);
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        data_d   = data_q;
        id_d     = id_q;
        sent_d   = sent_q;
        ovf_d    = ovf_q;
        credit_d = credit_q;

        if (can_grant) begin
            state_d = OFFER;
            data_d  = req_data_i[32'(win)*WIDTH +: WIDTH];
            id_d    = win;
            rr_d    = (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end else if (handshake) begin
            state_d = IDLE;
        end

        if (handshake) begin
            sent_d = sent_q + 7'd1;
        end

        credit_sum = {1'b0, credit_q}
                     + (token_i ? TOKEN_INC : '0)
                     - (CREDIT_W+1)'(can_grant);
        if (credit_sum > MAX_EXT) begin
            credit_d = CREDIT_W'(MAX_CREDITS);
            ovf_d    = 1'b1;
        end else begin
            credit_d = credit_sum[CREDIT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            data_q   <= '0;
            id_q     <= '0;
            credit_q <= CREDIT_W'(MAX_CREDITS);
            sent_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            data_q   <= data_d;
            id_q     <= id_d;
            credit_q <= credit_d;
            sent_q   <= sent_d;
            ovf_q    <= ovf_d;
        end
    end

    assign link_valid_o   = (state_q == OFFER);
    assign link_data_o    = data_q;
    assign link_id_o      = id_q;
    assign credit_o       = credit_q;
    assign sent_cnt_o     = sent_q;
    assign overflow_err_o = ovf_q;

endmodule

// File: tb/tb_bsg_link_upstream_credit_arbiter.sv
// Directed scenarios plus randomized traffic, compared against a cycle-level
// behavioural model of the credit arbiter kept in plain integers.
module tb_bsg_link_upstream_credit_arbiter;

    localparam int N    = 4;
    localparam int W    = 64;
    localparam int MAXC = 64;
    localparam int TOK  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid_i = '0;
    logic [N*W-1:0]   req_data_i  = '0;
    logic [N-1:0]     req_ready_o;
    logic             link_valid_o;
    logic [W-1:0]     link_data_o;
    logic [1:0]       link_id_o;
    logic             link_ready_i = 1'b0;
    logic             token_i = 1'b0;
    logic [6:0]       credit_o;
    logic [6:0]       sent_cnt_o;
    logic             stall_o;
    logic             overflow_err_o;

    bsg_link_upstream_credit_arbiter #(
        .NUM_REQ(N),
        .WIDTH(W),
        .MAX_CREDITS(MAXC),
        .LG_CREDIT_TO_TOKEN(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(req_valid_i),
        .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .link_valid_o(link_valid_o),
        .link_data_o(link_data_o),
        .link_id_o(link_id_o),
        .link_ready_i(link_ready_i),
        .token_i(token_i),
        .credit_o(credit_o),
        .sent_cnt_o(sent_cnt_o),
        .stall_o(stall_o),
        .overflow_err_o(overflow_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    bit          m_full;
    logic [63:0] m_data;
    int          m_id, m_rr, m_credit, m_sent;
    bit          m_ovf;
    int          m_win;
    logic [3:0]  exp_ready;
    logic [3:0]  obs_ready;
    logic        obs_stall;

    function automatic void model_reset();
        m_full = 0; m_data = '0; m_id = 0; m_rr = 0;
        m_credit = MAXC; m_sent = 0; m_ovf = 0;
    endfunction

    function automatic void model_comb();
        m_win = -1;
        if (m_credit > 0 && (!m_full || link_ready_i)) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_rr + k) % N;
                if (m_win < 0 && req_valid_i[idx]) m_win = idx;
            end
        end
        exp_ready = (m_win >= 0) ? 4'(1 << m_win) : 4'b0;
    endfunction

    function automatic void model_edge();
        int nxt;
        bit hs = m_full && link_ready_i;
        if (hs) m_sent = (m_sent + 1) % 128;
        nxt = m_credit + (token_i ? TOK : 0) - ((m_win >= 0) ? 1 : 0);
        if (nxt > MAXC) begin
            m_credit = MAXC;
            m_ovf = 1;
        end else begin
            m_credit = nxt;
        end
        if (m_win >= 0) begin
            m_full = 1;
            m_data = req_data_i[m_win*W +: W];
            m_id   = m_win;
            m_rr   = (m_win + 1) % N;
        end else if (hs) begin
            m_full = 0;
        end
    endfunction

    task automatic check_regs();
        check("link_valid", link_valid_o, m_full);
        check("link_id", link_id_o, m_id);
        check("link_data", link_data_o, m_data);
        check("credit", credit_o, m_credit);
        check("sent_cnt", sent_cnt_o, m_sent);
        check("overflow", overflow_err_o, m_ovf);
    endtask

    task automatic step(input logic [3:0] v, input logic rdy, input logic tok,
                        input bit use_fix = 0, input logic [63:0] fix = '0);
        @(negedge clk);
        req_valid_i  = v;
        link_ready_i = rdy;
        token_i      = tok;
        for (int i = 0; i < N; i++)
            req_data_i[i*W +: W] = use_fix ? fix : {$urandom, $urandom};
        #1;
        model_comb();
        obs_ready = req_ready_o;
        obs_stall = stall_o;
        check("req_ready", obs_ready, exp_ready);
        check("stall", obs_stall, (m_credit == 0) && (|v));
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid_i = '0; link_ready_i = 1'b0; token_i = 1'b0;
        model_reset();
        #1;
        check("rst_ready", req_ready_o, 0);
        check_regs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [63:0] held;

    initial begin
        model_reset();
        do_reset();

        // Single requester
        step(4'b0001, 1'b1, 1'b0, 1, 64'hA5A5_0000_0000_0001);
        check("single_valid", link_valid_o, 1);
        check("single_id", link_id_o, 0);
        check("single_data", link_data_o, 64'hA5A5_0000_0000_0001);
        check("single_credit", credit_o, 63);
        step(4'b0000, 1'b1, 1'b0);
        check("single_sent", sent_cnt_o, 1);

        // Round-robin, all valid
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 1'b1, 1'b0);
            check("rr_id", link_id_o, i % 4);
        end
        step(4'b0000, 1'b1, 1'b0);
        check("rr_credit", credit_o, 58);
        check("rr_sent", sent_cnt_o, 6);

        // Backpressure
        do_reset();
        step(4'b0100, 1'b1, 1'b0);
        held = link_data_o;
        check("bp_id0", link_id_o, 2);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0, 1'b0);
            check("bp_ready", obs_ready, 0);
            check("bp_id", link_id_o, 2);
            check("bp_data", link_data_o, held);
            check("bp_credit", credit_o, 63);
        end
        step(4'b1111, 1'b1, 1'b0);
        check("bp_release_ready", obs_ready, 4'b1000);
        check("bp_release_id", link_id_o, 3);
        check("bp_release_sent", sent_cnt_o, 1);

        // Credit exhaustion
        do_reset();
        for (int i = 0; i < MAXC; i++) step(4'b0010, 1'b1, 1'b0);
        check("ex_credit", credit_o, 0);
        step(4'b0010, 1'b1, 1'b0);
        check("ex_ready", obs_ready, 0);
        check("ex_stall", obs_stall, 1);
        step(4'b0010, 1'b1, 1'b1);
        check("ex_tok_no_grant", obs_ready, 0);
        check("ex_tok_credit", credit_o, 8);
        step(4'b0010, 1'b1, 1'b0);
        check("ex_resume", obs_ready, 4'b0010);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        check("five", credit_o, 5);
        step(4'b0010, 1'b1, 1'b1);
        check("tok_grant", credit_o, 12);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1, 1'b1);
        check("sixty", credit_o, 60);
        check("no_ovf", overflow_err_o, 0);
        step(4'b0000, 1'b1, 1'b1);
        check("sat_credit", credit_o, 64);
        check("ovf_set", overflow_err_o, 1);
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b1, 1'b0);
        check("ovf_sticky", overflow_err_o, 1);

        // Asynchronous reset mid-offer
        do_reset();
        step(4'b1111, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        check("ar_pre_valid", link_valid_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", link_valid_o, 0);
        check("ar_credit", credit_o, MAXC);
        check("ar_sent", sent_cnt_o, 0);
        check("ar_ovf", overflow_err_o, 0);
        check("ar_ready", req_ready_o, 0);
        model_reset();
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
